// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helpers, FSM state encoding and line levels.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VALUE sets the
// level both flops hold during reset (idle level of the line being synchronised).
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments keep the two stages as distinct flops.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises rx, samples each bit mid-bit, checks the stop
// bit and hands bytes out through a one-deep valid/ready holding register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_receiver: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic             rx_s;
  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  sync_2ff #(.RESET_VALUE(IDLE_LEVEL)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // NOTE: the consume clear comes first so a load later in this block overrides it.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_s != IDLE_LEVEL) begin
            state   <= ST_START;
            rx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s != IDLE_LEVEL) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state   <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              // Leave mid stop bit so a zero-gap next start edge is not missed.
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_BREAK_WAIT: begin
          if (rx_s == IDLE_LEVEL) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
